// File: rtl/buffer_branch_assoc.sv
// 2-way set-associative branch target buffer with saturating direction counters and per-set LRU.
// Optional BTB_GSHARE_EN moves the counters into a global-history-indexed PHT.
module btb_way_match #(
  parameter int TAG_BITS = 10
) (
  input  logic                valid,
  input  logic [TAG_BITS-1:0] stored,
  input  logic [TAG_BITS-1:0] look_tag,
  input  logic [TAG_BITS-1:0] upd_tag,
  output logic                look_match,
  output logic                upd_match
);
  assign look_match = valid && (stored == look_tag);
  assign upd_match  = valid && (stored == upd_tag);
endmodule

module buffer_branch_assoc #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 10,
  parameter int CTR_BITS   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_o,
  output logic        prediction,
  output logic        hit,
  input  logic        update,
  input  logic        committed,
  input  logic [31:0] current,
  input  logic [31:0] target,
  input  logic        invalidate
);
  localparam int SETS = 1 << INDEX_BITS;
  localparam int WAYS = 2;

  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0]   tag_t;
  typedef logic [CTR_BITS-1:0]   ctr_t;

  localparam ctr_t CTR_MAX  = {CTR_BITS{1'b1}};
  localparam ctr_t CTR_INIT = ctr_t'(1) << (CTR_BITS-1);

  function automatic ctr_t ctr_step(input ctr_t c, input logic up);
    if (up) return (c == CTR_MAX) ? c : c + ctr_t'(1);
    else    return (c == '0)      ? c : c - ctr_t'(1);
  endfunction

  // valid/LRU are reset; tag/target/counter payload is not
  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [SETS-1:0]           lru_q;
  tag_t                      tag_q [SETS][WAYS];
  logic [31:0]               tgt_q [SETS][WAYS];
`ifdef BTB_GSHARE_EN
  ctr_t                      pht_q [SETS];
  idx_t                      ghr_q;
`else
  ctr_t                      ctr_q [SETS][WAYS];
`endif

  idx_t            l_set, u_set;
  tag_t            l_tag, u_tag;
  logic [WAYS-1:0] l_match, u_match;
  logic            l_hit, l_way, l_taken;
  logic            u_hit, u_way, victim;

  assign l_set = pc_i[INDEX_BITS+1:2];
  assign l_tag = pc_i[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign u_set = current[INDEX_BITS+1:2];
  assign u_tag = current[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    btb_way_match #(.TAG_BITS(TAG_BITS)) u_match_w (
      .valid      (valid_q[l_set][w] & 1'b1),
      .stored     (tag_q[l_set][w]),
      .look_tag   (l_tag),
      .upd_tag    (l_tag),
      .look_match (l_match[w]),
      .upd_match  ()
    );
    btb_way_match #(.TAG_BITS(TAG_BITS)) u_umatch_w (
      .valid      (valid_q[u_set][w]),
      .stored     (tag_q[u_set][w]),
      .look_tag   (u_tag),
      .upd_tag    (u_tag),
      .look_match (u_match[w]),
      .upd_match  ()
    );
  end

  // way 0 wins a (should-be-impossible) double match
  assign l_hit  = |l_match;
  assign l_way  = ~l_match[0];
  assign u_hit  = |u_match;
  assign u_way  = ~u_match[0];
  assign victim = !valid_q[u_set][0] ? 1'b0 :
                  !valid_q[u_set][1] ? 1'b1 : lru_q[u_set];

`ifdef BTB_GSHARE_EN
  assign l_taken = pht_q[l_set ^ ghr_q][CTR_BITS-1];
`else
  assign l_taken = ctr_q[l_set][l_way][CTR_BITS-1];
`endif

  always_comb begin
    pc_o       = pc_i + 32'd4;
    prediction = 1'b0;
    hit        = 1'b0;
    if (reset) begin
      pc_o = '0;
    end else begin
      hit        = l_hit;
      prediction = l_hit && l_taken;
      if (l_hit && l_taken) pc_o = tgt_q[l_set][l_way];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || invalidate) begin
      valid_q <= '0;
      lru_q   <= '0;
`ifdef BTB_GSHARE_EN
      ghr_q   <= '0;
`endif
    end else if (update) begin
      if (u_hit) begin
        lru_q[u_set] <= ~u_way;
      end else if (committed) begin
        valid_q[u_set][victim] <= 1'b1;
        lru_q[u_set]           <= ~victim;
      end
`ifdef BTB_GSHARE_EN
      ghr_q <= idx_t'({ghr_q, committed});
`endif
    end
  end

  // payload writes share the control priority but carry no reset
  always_ff @(posedge clock) begin
    if (!reset && !invalidate && update) begin
      if (u_hit) begin
        if (committed) tgt_q[u_set][u_way] <= target;
`ifndef BTB_GSHARE_EN
        ctr_q[u_set][u_way] <= ctr_step(ctr_q[u_set][u_way], committed);
`endif
      end else if (committed) begin
        tag_q[u_set][victim] <= u_tag;
        tgt_q[u_set][victim] <= target;
`ifndef BTB_GSHARE_EN
        ctr_q[u_set][victim] <= CTR_INIT;
`endif
      end
`ifdef BTB_GSHARE_EN
      pht_q[u_set ^ ghr_q] <= ctr_step(pht_q[u_set ^ ghr_q], committed);
`endif
    end
  end

  logic unused_bits;
  assign unused_bits = ^{pc_i, current};

endmodule

// File: tb/tb_buffer_branch_assoc.sv
// Directed bench for buffer_branch_assoc: a CTR_BITS=2 instance plus a CTR_BITS=3 instance on shared inputs.
module tb_buffer_branch_assoc;
  logic        clock = 1'b0;
  logic        reset, update, committed, invalidate;
  logic [31:0] pc_i, current, target;
  logic [31:0] pc_o, pc_o3;
  logic        prediction, hit, prediction3, hit3;
  int          ncomp = 0;
  int          nfail = 0;

  always #5 clock = ~clock;

  buffer_branch_assoc #(.INDEX_BITS(6), .TAG_BITS(10), .CTR_BITS(2)) dut (
    .clock(clock), .reset(reset), .pc_i(pc_i), .pc_o(pc_o), .prediction(prediction),
    .hit(hit), .update(update), .committed(committed), .current(current),
    .target(target), .invalidate(invalidate));

  buffer_branch_assoc #(.INDEX_BITS(6), .TAG_BITS(10), .CTR_BITS(3)) dut3 (
    .clock(clock), .reset(reset), .pc_i(pc_i), .pc_o(pc_o3), .prediction(prediction3),
    .hit(hit3), .update(update), .committed(committed), .current(current),
    .target(target), .invalidate(invalidate));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ncomp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic upd(input logic [31:0] cur, input logic [31:0] tgt, input logic taken);
    current = cur; target = tgt; committed = taken; update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic [31:0] epc,
                      input logic epred, input logic ehit);
    pc_i = pc;
    #1;
    chk({name, ".pc_o"}, pc_o, epc);
    chk({name, ".pred"}, {31'd0, prediction}, {31'd0, epred});
    chk({name, ".hit"},  {31'd0, hit},        {31'd0, ehit});
  endtask

  initial begin
    reset = 1'b1; update = 1'b0; committed = 1'b0; invalidate = 1'b0;
    pc_i = 32'h100; current = '0; target = '0;
    tick();
    #1;
    chk("rst.pc_o", pc_o, 32'h0);
    chk("rst.pred", {31'd0, prediction}, 32'd0);
    chk("rst.hit",  {31'd0, hit}, 32'd0);
    tick();
    reset = 1'b0;

    look("cold", 32'h100, 32'h104, 1'b0, 1'b0);

    // lookup in the same cycle as the allocating update sees the old table
    current = 32'h100; target = 32'h400; committed = 1'b1; update = 1'b1; pc_i = 32'h100;
    #1;
    chk("same.hit",  {31'd0, hit}, 32'd0);
    chk("same.pc_o", pc_o, 32'h104);
    tick();
    update = 1'b0;
    look("alloc", 32'h100, 32'h400, 1'b1, 1'b1);

    upd(32'h100, 32'h400, 1'b0);
    look("nt1", 32'h100, 32'h104, 1'b0, 1'b1);
    upd(32'h100, 32'h400, 1'b0);
    look("nt2", 32'h100, 32'h104, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) upd(32'h100, 32'h400, 1'b1);
    upd(32'h100, 32'h400, 1'b0);
    look("sat", 32'h100, 32'h400, 1'b1, 1'b1);

    upd(32'h200, 32'h500, 1'b1);
    upd(32'h300, 32'h600, 1'b1);
    look("evict100", 32'h100, 32'h104, 1'b0, 1'b0);
    look("keep200",  32'h200, 32'h500, 1'b1, 1'b1);
    look("new300",   32'h300, 32'h600, 1'b1, 1'b1);

    upd(32'h700, 32'h777, 1'b0);
    look("nt_noalloc", 32'h700, 32'h704, 1'b0, 1'b0);
    look("still200",   32'h200, 32'h500, 1'b1, 1'b1);

    upd(32'h300, 32'h800, 1'b1);
    look("retarget", 32'h300, 32'h800, 1'b1, 1'b1);
    upd(32'h300, 32'h123, 1'b0);
    look("nt_keep_tgt", 32'h300, 32'h800, 1'b1, 1'b1);

    upd(32'h900, 32'hA00, 1'b1);
    look("evict200", 32'h200, 32'h204, 1'b0, 1'b0);
    look("new900",   32'h900, 32'hA00, 1'b1, 1'b1);
    // hit on way 0 must steer the next eviction to way 1
    upd(32'h300, 32'h800, 1'b1);
    upd(32'hB00, 32'hC00, 1'b1);
    look("evict900", 32'h900, 32'h904, 1'b0, 1'b0);
    look("lru300",   32'h300, 32'h800, 1'b1, 1'b1);
    look("newB00",   32'hB00, 32'hC00, 1'b1, 1'b1);

    current = 32'h140; target = 32'h444; committed = 1'b1; update = 1'b1; invalidate = 1'b1;
    tick();
    update = 1'b0; invalidate = 1'b0;
    look("inv300", 32'h300, 32'h304, 1'b0, 1'b0);
    look("invB00", 32'hB00, 32'hB04, 1'b0, 1'b0);
    look("inv140", 32'h140, 32'h144, 1'b0, 1'b0);

    look("wrap", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);

    upd(32'h300, 32'h600, 1'b1);
    look("realloc", 32'h300, 32'h600, 1'b1, 1'b1);
    reset = 1'b1;
    pc_i = 32'h300;
    #1;
    chk("midrst.pc_o", pc_o, 32'h0);
    chk("midrst.hit",  {31'd0, hit}, 32'd0);
    tick();
    reset = 1'b0;
    look("postrst", 32'h300, 32'h304, 1'b0, 1'b0);

    // 3-bit counter starts at 4: taken, one not-taken drops to 3, one taken back to 4
    upd(32'h100, 32'h400, 1'b1);
    pc_i = 32'h100;
    #1;
    chk("c3.init.pred", {31'd0, prediction3}, 32'd1);
    chk("c3.init.pc_o", pc_o3, 32'h400);
    upd(32'h100, 32'h400, 1'b0);
    #1;
    chk("c3.dec.pred", {31'd0, prediction3}, 32'd0);
    chk("c3.dec.hit",  {31'd0, hit3}, 32'd1);
    upd(32'h100, 32'h400, 1'b1);
    #1;
    chk("c3.inc.pred", {31'd0, prediction3}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
